// File: rtl/dpd_adapt_seq.sv
// dpd_adapt_seq: DPD LMS adaptation sequencer. Generates train_en, sw_fb and
// coef_upd windows per iteration; n_iter iterations with idle gaps.
// Ports: clk, reset_b (async, active-low), start (2-FF synced, rising edge),
// abort (sync level), dly[7:0], n_iter[3:0], cont (DPD_SEQ_CONT_EN only);
// outputs train_en, sw_fb, coef_upd, busy, done, aborted, iter_cnt[3:0].
// Macro DPD_SEQ_CONT_EN adds input cont for continuous looping.
module dpd_adapt_seq #(
  parameter int CW        = 16,
  parameter int TRAIN_LEN = 800,
  parameter int COEF_LO   = 150,
  parameter int COEF_HI   = 700,
  parameter int GAP_LEN   = 64
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] dly,
  input  logic [3:0] n_iter,
`ifdef DPD_SEQ_CONT_EN
  input  logic       cont,
`endif
  output logic       train_en,
  output logic       sw_fb,
  output logic       coef_upd,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] iter_cnt
);

  typedef enum logic [1:0] {
    IDLE, RUN, GAP, DONE
  } state_t;

  localparam logic [CW:0]   TL  = (CW+1)'(TRAIN_LEN);
  localparam logic [CW:0]   LO  = (CW+1)'(COEF_LO);
  localparam logic [CW:0]   HI  = (CW+1)'(COEF_HI);
  localparam logic [CW:0]   X1  = (CW+1)'(1);
  localparam logic [CW-1:0] C1  = CW'(1);
  localparam logic [CW-1:0] GL1 = CW'(GAP_LEN - 1);

  state_t        state_q, state_d;
  logic          s0_q, s1_q, st_edge;
  logic [CW-1:0] c_q, c_d, g_q, g_d;
  logic [7:0]    dly_q, dly_d;
  logic [3:0]    nit_q, nit_d;
  logic [3:0]    iter_q, iter_d, iter_inc;
  logic          train_q, train_d;
  logic          fb_q, fb_d;
  logic          coef_q, coef_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abt_q, abt_d;
  logic          run, cont_w;
  logic [CW:0]   c_x, d_x, end_x;

`ifdef DPD_SEQ_CONT_EN
  assign cont_w = cont;
`else
  assign cont_w = 1'b0;
`endif

  assign st_edge  = s0_q & ~s1_q;
  assign iter_inc = iter_q + 4'd1;
  // Extra bit keeps dly+TRAIN_LEN from wrapping.
  assign c_x   = {1'b0, c_q};
  assign d_x   = {{(CW-7){1'b0}}, dly_q};
  assign end_x = d_x + TL;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    g_d     = g_q;
    dly_d   = dly_q;
    nit_d   = nit_q;
    iter_d  = iter_q;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (st_edge && !abort) begin
          state_d = RUN;
          c_d     = '0;
          iter_d  = '0;
          dly_d   = dly;
          nit_d   = (n_iter == 4'd0) ? 4'd1 : n_iter;
        end
      end
      RUN: begin
        c_d = c_q + C1;
        if (c_x == end_x) begin
          iter_d  = iter_inc;
          state_d = GAP;
          g_d     = '0;
          if (iter_inc == nit_q) begin
            if (cont_w) begin
              // Wrap into the next run without leaving busy.
              done_d = 1'b1;
              iter_d = '0;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      GAP: begin
        g_d = g_q + C1;
        if (g_q == GL1) begin
          state_d = RUN;
          c_d     = '0;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      iter_d  = iter_q;
      done_d  = 1'b0;
      abt_d   = 1'b1;
    end
  end

  assign run     = (state_q == RUN) && !abort;
  assign train_d = run && (c_x >= X1) && (c_x <= TL);
  assign fb_d    = run && (c_x >= d_x + X1) &&
                   (c_x <= end_x);
  assign coef_d  = run && (c_x >= d_x + LO) &&
                   (c_x <= d_x + HI);
  assign busy_d  = (state_d != IDLE);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      c_q     <= '0;
      g_q     <= '0;
      dly_q   <= '0;
      nit_q   <= '0;
      iter_q  <= '0;
      train_q <= 1'b0;
      fb_q    <= 1'b0;
      coef_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= start;
      s1_q    <= s0_q;
      c_q     <= c_d;
      g_q     <= g_d;
      dly_q   <= dly_d;
      nit_q   <= nit_d;
      iter_q  <= iter_d;
      train_q <= train_d;
      fb_q    <= fb_d;
      coef_q  <= coef_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  assign train_en = train_q;
  assign sw_fb    = fb_q;
  assign coef_upd = coef_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = abt_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_dpd_adapt_seq.sv
// tb_dpd_adapt_seq: directed bench for dpd_adapt_seq.
// Window/pulse events are scored against an expected-event queue.
module tb_dpd_adapt_seq;
  localparam int TL = 800;
  localparam int LO = 150;
  localparam int HI = 700;
  localparam int GL = 64;
  localparam int K_GAP = 0;
  localparam int K_CF  = 1;
  localparam int K_TR  = 2;
  localparam int K_FB  = 3;
  localparam int K_DN  = 4;
  localparam int K_AB  = 5;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] dly = 8'd0;
  logic [3:0] n_iter = 4'd0;
`ifdef DPD_SEQ_CONT_EN
  logic       cont = 1'b0;
`endif
  logic       train_en, sw_fb, coef_upd;
  logic       busy, done, aborted;
  logic [3:0] iter_cnt;

  dpd_adapt_seq dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .start    (start),
    .abort    (abort),
    .dly      (dly),
    .n_iter   (n_iter),
`ifdef DPD_SEQ_CONT_EN
    .cont     (cont),
`endif
    .train_en (train_en),
    .sw_fb    (sw_fb),
    .coef_upd (coef_upd),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    int a;
    int b;
  } ev_t;

  ev_t exp_q[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  int tr_r = 0, fb_r = 0, cf_r = 0, gapc = 0;
  logic p_tr = 0, p_fb = 0, p_cf = 0;

  function automatic string kname(int k);
    case (k)
      K_GAP:   return "gap";
      K_CF:    return "coef";
      K_TR:    return "train";
      K_FB:    return "fb";
      K_DN:    return "done";
      default: return "abort";
    endcase
  endfunction

  function automatic void chk(string tag, int got, int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d",
                tag, got, exp);
  endfunction

  function automatic void push(int k, int a, int b);
    ev_t e;
    e.k = k;
    e.a = a;
    e.b = b;
    exp_q.push_back(e);
  endfunction

  // w=1: a cont wrap done lands before the fb fall.
  function automatic void exp_iter(int d, int gap, int w);
    push(K_GAP, gap, 0);
    push(K_CF, HI - LO + 1, d + LO - 1);
    push(K_TR, TL, 0);
    if (w != 0) push(K_DN, 0, 1);
    push(K_FB, TL, d);
  endfunction

  function automatic void got_ev(int k, int a, int b);
    ev_t e;
    total++;
    assert (exp_q.size() != 0) passed++;
    else $error("FAIL unexpected_%s: got a=%0d b=%0d expected none",
                kname(k), a, b);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({"kind_", kname(e.k)}, k, e.k);
      chk({kname(e.k), "_a"}, a, e.a);
      chk({kname(e.k), "_b"}, b, e.b);
    end
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset_b) begin
      p_tr = 0;
      p_fb = 0;
      p_cf = 0;
      gapc = 0;
    end else begin
      if (train_en && !p_tr) begin
        tr_r = cyc;
        rise_cnt++;
        got_ev(K_GAP, gapc, 0);
      end
      if (sw_fb && !p_fb) fb_r = cyc;
      if (coef_upd && !p_cf) cf_r = cyc;
      if (!coef_upd && p_cf)
        got_ev(K_CF, cyc - cf_r, cf_r - tr_r);
      if (!train_en && p_tr)
        got_ev(K_TR, cyc - tr_r, 0);
      if (!sw_fb && p_fb)
        got_ev(K_FB, cyc - fb_r, fb_r - tr_r);
      if (done) begin
        done_cnt++;
        got_ev(K_DN, int'(iter_cnt), int'(busy));
      end
      if (aborted)
        got_ev(K_AB, int'(iter_cnt),
               int'(busy | train_en | sw_fb | coef_upd));
      if (busy && !train_en && !sw_fb && !coef_upd)
        gapc++;
      else
        gapc = 0;
      p_tr = train_en;
      p_fb = sw_fb;
      p_cf = coef_upd;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_start(int d, int n);
    dly = 8'(d);
    n_iter = 4'(n);
    pulse_start();
  endtask

  task automatic wait_busy(logic want, int budget);
    int i = 0;
    while (busy !== want && i < budget) begin
      tick(1);
      i++;
    end
    chk("busy_wait", int'(busy), int'(want));
  endtask

  task automatic wait_rise(int n, int budget);
    int i = 0;
    while (rise_cnt < n && i < budget) begin
      tick(1);
      i++;
    end
    chk("rise_wait", int'(rise_cnt >= n), 1);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_train"}, int'(train_en), 0);
    chk({tag, "_fb"}, int'(sw_fb), 0);
    chk({tag, "_coef"}, int'(coef_upd), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int r0;
    tick(3);
    chk_quiet("rst");
    chk("rst_done", int'(done), 0);
    chk("rst_abt", int'(aborted), 0);
    chk("rst_iter", int'(iter_cnt), 0);
    reset_b = 1'b1;
    tick(3);

    exp_iter(41, 2, 0);
    push(K_DN, 1, 0);
    run_start(41, 1);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 3000);
    tick(5);
    chk("t1_iter", int'(iter_cnt), 1);
    chk("t1_q", exp_q.size(), 0);

    exp_iter(10, 2, 0);
    exp_iter(10, GL + 1, 0);
    exp_iter(10, GL + 1, 0);
    push(K_DN, 3, 0);
    run_start(10, 3);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 5000);
    tick(5);
    chk("t2_iter", int'(iter_cnt), 3);
    chk("t2_q", exp_q.size(), 0);

    exp_iter(10, 2, 0);
    push(K_DN, 1, 0);
    run_start(10, 0);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 3000);
    tick(5);
    chk("t2b_q", exp_q.size(), 0);

    exp_iter(41, 2, 0);
    push(K_GAP, GL + 1, 0);
    push(K_CF, 109, 190);
    push(K_TR, 299, 0);
    push(K_FB, 258, 41);
    push(K_AB, 1, 0);
    r0 = rise_cnt;
    run_start(41, 3);
    wait_rise(r0 + 2, 3000);
    repeat (297) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk_quiet("t3");
    tick(20);
    chk("t3_iter", int'(iter_cnt), 1);
    chk("t3_q", exp_q.size(), 0);

    exp_iter(41, 2, 0);
    push(K_DN, 1, 0);
    run_start(41, 1);
    wait_busy(1'b1, 20);
    tick(100);
    dly = 8'd99;
    pulse_start();
    wait_busy(1'b0, 3000);
    tick(20);
    chk("t4_busy", int'(busy), 0);
    chk("t4_q", exp_q.size(), 0);
    abort = 1'b1;
    pulse_start();
    tick(4);
    abort = 1'b0;
    tick(10);
    chk("t4b_busy", int'(busy), 0);
    chk("t4b_q", exp_q.size(), 0);

    push(K_GAP, 2, 0);
    r0 = rise_cnt;
    run_start(41, 1);
    wait_rise(r0 + 1, 100);
    repeat (497) @(posedge clk);
    #3 reset_b = 1'b0;
    #1;
    chk_quiet("t5_rst");
    chk("t5_iter", int'(iter_cnt), 0);
    tick(3);
    reset_b = 1'b1;
    tick(5);
    chk("t5_busy", int'(busy), 0);
    chk("t5_q", exp_q.size(), 0);
    exp_iter(0, 2, 0);
    push(K_DN, 1, 0);
    run_start(0, 1);
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 3000);
    tick(5);
    chk("t5b_q", exp_q.size(), 0);

`ifdef DPD_SEQ_CONT_EN
    cont = 1'b1;
    exp_iter(10, 2, 0);
    exp_iter(10, GL + 1, 1);
    exp_iter(10, GL + 1, 0);
    exp_iter(10, GL + 1, 1);
    exp_iter(10, GL + 1, 0);
    exp_iter(10, GL + 1, 0);
    push(K_DN, 2, 0);
    r0 = done_cnt;
    run_start(10, 2);
    begin
      int i = 0;
      while (done_cnt < r0 + 2 && i < 6000) begin
        tick(1);
        i++;
      end
    end
    chk("t6_busy", int'(busy), 1);
    cont = 1'b0;
    wait_busy(1'b0, 3000);
    tick(5);
    chk("t6_q", exp_q.size(), 0);
`endif

    tick(5);
    chk("final_q", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
